flux_line_scheduler: RTL



---
 rtl/flux_line_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/flux_line_scheduler.sv
// Round-robin flux arbiter with bounded burst locking and a sticky per-flux
// starvation monitor. Grant, valid and tag are combinational from req/flux_en.
module flux_line_scheduler #(
    parameter int FLUX         = 2,
    parameter int BURST        = 4,
    parameter int STARVE_LIMIT = 64,
    localparam int TAG_WIDTH   = $clog2(FLUX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      req,
    input  logic [FLUX-1:0]      flux_en,
    input  logic                 block_done,
    input  logic                 starve_clr,
    output logic [FLUX-1:0]      grant,
    output logic                 grant_valid,
    output logic [TAG_WIDTH:0]   grant_tag,
    output logic [FLUX-1:0]      starve,
    output logic                 dbg_hold_o
);

    localparam int CW = $clog2(BURST + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]        BURST_C = CW'(BURST);
    localparam logic [WW-1:0]        LIMIT_C = WW'(STARVE_LIMIT);
    localparam logic [TAG_WIDTH-1:0] LAST_C  = TAG_WIDTH'(FLUX - 1);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   ptr_q, ptr_d;
    logic [TAG_WIDTH-1:0]   owner_q, owner_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_n;
    logic [WW-1:0]          wait_q [FLUX];
    logic [WW-1:0]          wait_d [FLUX];
    logic [FLUX-1:0]        starve_q, starve_d;

    logic [FLUX-1:0]        r;
    logic [FLUX-1:0]        gnt_raw;
    logic [TAG_WIDTH-1:0]   gnt_idx;
    logic [TAG_WIDTH-1:0]   cand;
    logic                   found;

    // The owner keeps the line while it still requests; otherwise the first
    // requester at or after ptr wins, so a dropped owner never idles the line.
    always_comb begin
        r       = req & flux_en;
        found   = 1'b0;
        gnt_idx = '0;
        cand    = ptr_q;
        if (state_q == ST_HOLD && r[owner_q]) begin
            found   = 1'b1;
            gnt_idx = owner_q;
        end else begin
            for (int k = 0; k < FLUX; k++) begin
                if (!found && r[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
                cand = (cand == LAST_C) ? '0 : cand + 1'b1;
            end
        end
        for (int i = 0; i < FLUX; i++) begin
            gnt_raw[i] = found && (gnt_idx == TAG_WIDTH'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cnt_n   = (state_q == ST_HOLD && gnt_idx == owner_q) ? cnt_q + 1'b1 : CW'(1);
        if (found) begin
            ptr_d = (gnt_idx == LAST_C) ? '0 : gnt_idx + 1'b1;
            if (block_done || cnt_n == BURST_C) begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end else begin
                state_d = ST_HOLD;
                owner_d = gnt_idx;
                cnt_d   = cnt_n;
            end
        end else begin
            state_d = ST_ARB;
            cnt_d   = '0;
        end
    end

    // Wait counters saturate; starve_clr beats a same-cycle starvation set.
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            wait_d[i] = wait_q[i];
            if (starve_clr || !r[i] || gnt_raw[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != LIMIT_C) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
            starve_d[i] = !starve_clr && (starve_q[i] || (wait_d[i] == LIMIT_C));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARB;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            for (int i = 0; i < FLUX; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            for (int i = 0; i < FLUX; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign grant       = rst ? '0 : gnt_raw;
    assign grant_valid = |grant;
    assign grant_tag   = grant_valid ? {1'b0, gnt_idx} : '1;
    assign starve      = rst ? '0 : starve_q;
    assign dbg_hold_o  = (state_q == ST_HOLD);

endmodule
